// File: rtl/imem_responder.sv
// imem_responder: serves a 64-bit big-endian fetch window from a 32-bit word
// array read one word per cycle, with a byte-wide load port for boot/sim fill.
module imem_responder #(
  parameter int DEPTH_WORDS = 16,
  parameter int ADDR_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ready_o,
  output logic              fetch_valid_o,
  output logic [63:0]       fetch_data_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [7:0]        load_data_i
);
  localparam int CAP_W  = $clog2(4*DEPTH_WORDS);
  localparam int WIDX_W = CAP_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [31:0]         r_mem [DEPTH_WORDS];
  logic [WIDX_W-1:0]   r_w0;
  logic [1:0]          r_off;
  logic [1:0]          r_beat;
  logic [ADDR_W-1:0]   r_a;
  logic [63:0]         r_sh;        // previously read words; current word joins combinationally
  logic                r_valid;
  logic [63:0]         r_data;
  logic [ADDR_W-1:0]   r_addr;

  logic [WIDX_W-1:0]   w_rd_idx;
  logic [31:0]         w_rd;
  logic                w_last;
  logic [95:0]         w_asm;
  logic [6:0]          w_base;
  logic [63:0]         w_win;
  logic [WIDX_W-1:0]   w_ld_idx;
  logic [4:0]          w_ld_bit;
  logic                w_unused;

  // upper load-address bits wrap away; kept only to make that explicit
  assign w_unused = ^load_addr_i[ADDR_W-1:CAP_W];

  assign fetch_ready_o = (r_state == S_IDLE) && !reset;
  assign fetch_valid_o = r_valid;
  assign fetch_data_o  = r_data;
  assign fetch_addr_o  = r_addr;

  // read port: the word for the current beat, wrapping around the array
  assign w_rd_idx = r_w0 + WIDX_W'(r_beat);
  assign w_rd     = r_mem[w_rd_idx];
  // aligned fetches need 2 beats, unaligned need 3
  assign w_last   = (r_off == 2'd0) ? (r_beat == 2'd1) : (r_beat == 2'd2);
  // assembled words, oldest first; for 2 beats only the low 64 bits are meaningful
  assign w_asm    = {r_sh, w_rd};
  assign w_base   = (r_off == 2'd0) ? 7'd0 : 7'd32 - {2'b00, r_off, 3'b000};
  assign w_win    = 64'(w_asm >> w_base);

  // byte lane 0 is the most significant byte of the word
  assign w_ld_idx = load_addr_i[CAP_W-1:2];
  assign w_ld_bit = {~load_addr_i[1:0], 3'b000};

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (fetch_req_i) w_next = S_FETCH;
      S_FETCH: if (w_last)      w_next = S_RESP;
      S_RESP:                   w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // fetch datapath: latch request, gather words, register the window
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_beat  <= '0;
      r_w0    <= '0;
      r_off   <= '0;
      r_a     <= '0;
      r_sh    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (fetch_req_i) begin
          r_w0   <= fetch_addr_i[CAP_W-1:2];
          r_off  <= fetch_addr_i[1:0];
          r_a    <= fetch_addr_i;
          r_beat <= '0;
        end
        S_FETCH: begin
          r_sh   <= {r_sh[31:0], w_rd};
          r_beat <= r_beat + 2'd1;
          if (w_last) begin
            r_data  <= w_win;
            r_addr  <= r_a;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // load port: independent of the FSM and of reset; reads see old data same cycle
  always_ff @(posedge clk) begin
    if (load_we_i) r_mem[w_ld_idx][w_ld_bit +: 8] <= load_data_i;
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed test-plan steps then randomized
// loads/fetches compared against a byte-array model of the memory.
module tb_imem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req_i;
  logic [24:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic        fetch_valid_o;
  logic [63:0] fetch_data_o;
  logic [24:0] fetch_addr_o;
  logic        load_we_i;
  logic [24:0] load_addr_i;
  logic [7:0]  load_data_i;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] model_mem [64];

  imem_responder #(.DEPTH_WORDS(16), .ADDR_W(25)) dut (
    .clk(clk), .reset(reset),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_ready_o(fetch_ready_o), .fetch_valid_o(fetch_valid_o),
    .fetch_data_o(fetch_data_o), .fetch_addr_o(fetch_addr_o),
    .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // expected window: 8 bytes from A upward, wrapping at the byte capacity
  function automatic logic [63:0] model_win(input logic [24:0] a);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], model_mem[(int'(a) + i) % 64]};
    return r;
  endfunction

  task automatic load_byte(input logic [24:0] a, input logic [7:0] d);
    load_we_i = 1'b1; load_addr_i = a; load_data_i = d;
    tick;
    load_we_i = 1'b0;
    model_mem[int'(a) % 64] = d;
  endtask

  // one complete fetch; optional byte write on the edge after acceptance (E1)
  task automatic do_fetch(input logic [24:0] a, input logic [63:0] exp, input string tag,
                          input bit ld_en = 1'b0, input logic [24:0] ld_a = '0,
                          input logic [7:0] ld_d = '0);
    int n;
    bit got;
    n = 0;
    while (!fetch_ready_o && n < 20) begin tick; n++; end
    check({tag, " ready_before"}, 64'(fetch_ready_o), 64'd1);
    fetch_req_i = 1'b1; fetch_addr_i = a;
    tick;
    fetch_req_i = 1'b0; fetch_addr_i = 25'($urandom);
    if (ld_en) begin load_we_i = 1'b1; load_addr_i = ld_a; load_data_i = ld_d; end
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      tick;
      load_we_i = 1'b0;
      n++;
      got = fetch_valid_o;
    end
    check({tag, " latency"}, 64'(n), (a[1:0] == 2'd0) ? 64'd2 : 64'd3);
    check({tag, " data"}, fetch_data_o, exp);
    check({tag, " addr"}, 64'(fetch_addr_o), 64'(a));
    tick;
    check({tag, " pulse_end"}, 64'(fetch_valid_o), 64'd0);
    check({tag, " ready_after"}, 64'(fetch_ready_o), 64'd1);
    check({tag, " data_hold"}, fetch_data_o, exp);
    if (ld_en) model_mem[int'(ld_a) % 64] = ld_d;
  endtask

  initial begin
    logic [7:0] prog [12];
    logic [24:0] ra;
    prog = '{8'h11, 8'hC1, 8'h12, 8'h5F, 8'h21, 8'h41, 8'h1E, 8'hC1,
             8'h00, 8'h0B, 8'h49, 8'hE1};
    reset = 1'b1; fetch_req_i = 1'b0; fetch_addr_i = '0;
    load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;

    // preload while reset is held: loads must still land
    for (int i = 0; i < 64; i++) begin
      load_byte(25'(i), (i < 12) ? prog[i] : 8'h00);
      if (i == 1) begin
        check("reset ready", 64'(fetch_ready_o), 64'd0);
        check("reset valid", 64'(fetch_valid_o), 64'd0);
        check("reset data", fetch_data_o, 64'd0);
        check("reset addr", 64'(fetch_addr_o), 64'd0);
      end
    end
    reset = 1'b0;
    #1;
    check("ready after reset", 64'(fetch_ready_o), 64'd1);

    do_fetch(25'd0, 64'h11C1125F21411EC1, "A0");
    do_fetch(25'd2, 64'h125F21411EC1000B, "A2");
    do_fetch(25'd6, 64'h1EC1000B49E10000, "A6");

    // busy: request held every cycle, A=0 then A=4
    fetch_req_i = 1'b1; fetch_addr_i = 25'd0;
    tick;                                   // E0 accepts A=0
    fetch_addr_i = 25'd4;
    check("busy E0 ready", 64'(fetch_ready_o), 64'd0);
    tick;                                   // E1
    check("busy E1 valid", 64'(fetch_valid_o), 64'd0);
    tick;                                   // E2
    check("busy E2 valid", 64'(fetch_valid_o), 64'd1);
    check("busy E2 data", fetch_data_o, 64'h11C1125F21411EC1);
    check("busy E2 ready", 64'(fetch_ready_o), 64'd0);
    tick;                                   // E3 back to idle
    check("busy E3 valid", 64'(fetch_valid_o), 64'd0);
    check("busy E3 ready", 64'(fetch_ready_o), 64'd1);
    tick;                                   // E4 accepts A=4
    fetch_req_i = 1'b0;
    tick;
    check("busy E5 valid", 64'(fetch_valid_o), 64'd0);
    tick;
    check("busy E6 valid", 64'(fetch_valid_o), 64'd1);
    check("busy E6 data", fetch_data_o, 64'h21411EC1000B49E1);
    check("busy E6 addr", 64'(fetch_addr_o), 64'd4);
    tick;
    check("busy E7 valid", 64'(fetch_valid_o), 64'd0);

    // wrap-around
    load_byte(25'd60, 8'hAA); load_byte(25'd61, 8'hBB);
    load_byte(25'd62, 8'hCC); load_byte(25'd63, 8'hDD);
    do_fetch(25'd62, 64'hCCDD11C1125F2141, "wrap62");
    do_fetch(25'd64, 64'h11C1125F21411EC1, "wrap64");

    // reset mid-fetch
    fetch_req_i = 1'b1; fetch_addr_i = 25'd2;
    tick;
    fetch_req_i = 1'b0; reset = 1'b1;
    tick;
    check("rst ready", 64'(fetch_ready_o), 64'd0);
    check("rst data", fetch_data_o, 64'd0);
    check("rst addr", 64'(fetch_addr_o), 64'd0);
    reset = 1'b0;
    #1;
    check("rst ready_after", 64'(fetch_ready_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rst no_valid", 64'(fetch_valid_o), 64'd0);
    end
    do_fetch(25'd0, 64'h11C1125F21411EC1, "after_rst");

    // loads racing a fetch
    do_fetch(25'd0, 64'h11C1125F21FF1EC1, "ld_b5", 1'b1, 25'd5, 8'hFF);
    do_fetch(25'd0, 64'h11C1125F21FF1EC1, "ld_b1", 1'b1, 25'd1, 8'h77);
    do_fetch(25'd0, 64'h1177125F21FF1EC1, "ld_b1_seen");

    // randomized loads and fetches against the model
    for (int k = 0; k < 30; k++) begin
      for (int j = 0; j < 3; j++) load_byte(25'($urandom), 8'($urandom));
      ra = 25'($urandom);
      do_fetch(ra, model_win(ra), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves the fetch stage's 64-bit fetch window. It accepts a byte address from the instruction fetcher and returns the 8 bytes starting at that address, packed most-significant-byte first. Contents live in an internal 32-bit-wide word array that is read one word per cycle. A byte-wide load port fills the array for simulation and boot.

## Interface
Parameters:
- DEPTH_WORDS, 16, number of 32-bit words stored; power of two, at least 4. Byte capacity is 4*DEPTH_WORDS.
- ADDR_W, 25, byte-address width, matching the PC width.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req_i  in  1  fetch request; sampled only while fetch_ready_o=1.
- fetch_addr_i  in  ADDR_W  byte address of the first window byte.
- fetch_ready_o  out  1  high in IDLE and not in reset.
- fetch_valid_o  out  1  one-cycle pulse; fetch_data_o and fetch_addr_o are valid.
- fetch_data_o  out  64  window: [63:56]=byte[A], [55:48]=byte[A+1], …, [7:0]=byte[A+7].
- fetch_addr_o  out  ADDR_W  echo of the accepted address.
- load_we_i  in  1  byte write enable.
- load_addr_i  in  ADDR_W  byte write address, taken modulo the byte capacity.
- load_data_i  in  8  write data.

## Operation
- Storage and byte order:
  - Word w holds bytes 4w..4w+3, with [31:24]=byte 4w (big-endian).
  - The array is not cleared by reset.
- Address handling:
  - All byte addresses are taken modulo 4*DEPTH_WORDS; upper address bits are ignored.
  - w0 = word index of the accepted address A.
  - off = A[1:0].
  - beats = 2 if off==0, otherwise 3.
- IDLE:
  - fetch_ready_o=1.
  - On fetch_req_i=1, latch A and beat count, clear the beat counter, go to FETCH.
- FETCH:
  - Each edge reads word (w0+beat) mod DEPTH_WORDS into a 96-bit shift register, then increments beat.
  - On the edge that reads the last beat:
    - Register fetch_data_o, selecting the 64 bits at byte offset off from the assembled words (current word included).
    - Set fetch_addr_o=A and fetch_valid_o=1.
    - Go to RESP.
- RESP:
  - fetch_valid_o=1 for exactly this cycle.
  - fetch_ready_o=0.
  - Next edge returns to IDLE with fetch_valid_o=0.
- Requests while fetch_ready_o=0 are ignored and are not queued.
- Load port:
  - Independent of the FSM; writes the byte on any edge where load_we_i=1.
  - A word read in the same cycle as a write to that word returns the old contents (read-before-write).
  - Later beats of the same fetch see the new byte.
- Reset:
  - state=IDLE, fetch_valid_o=0, fetch_data_o=0, fetch_addr_o=0, beat counter=0.
  - fetch_ready_o=0 while reset is high.
  - Reset during FETCH or RESP aborts the fetch; no valid pulse follows.
  - A load write in a reset cycle is still performed.

## Timing
- Acceptance edge E0 is the edge where fetch_ready_o=1 and fetch_req_i=1.
- Aligned request: words are read at E1 and E2; fetch_valid_o is high in the cycle after E2; fetch_ready_o is high again after E3.
- Unaligned request: words are read at E1–E3; fetch_valid_o is high in the cycle after E3.
- Maximum throughput: one aligned fetch per 4 cycles, one unaligned fetch per 5 cycles.
- fetch_data_o and fetch_addr_o hold their value after the valid pulse until the next response.

## Test plan
Preload bytes 0..11 with 11 C1 12 5F 21 41 1E C1 00 0B 49 E1 (ADD, ADD, AND, ANDI+imm, CMP); all other bytes are 00. DEPTH_WORDS=16.

- Aligned fetch, A=0 → valid in the 2nd cycle after E0 (cycle after E2), fetch_data_o=0x11C1125F21411EC1, fetch_addr_o=0; pulse lasts 1 cycle.
- Halfword-offset fetch, A=2 → valid in the 3rd cycle after E0 (cycle after E3), data=0x125F21411EC1000B. A=6 → data=0x1EC1000B49E10000.
- Wrap-around: load bytes 60..63 = AA BB CC DD, fetch A=62 → data=0xCCDD11C1125F2141. Fetch A=64+0 (bit above capacity set) → same data as A=0.
- Busy handling: assert fetch_req_i every cycle with A=0, then A=4 → exactly one response per accepted request; A=4 is accepted only after the A=0 response completes (ready high again after E3); A=4 data=0x21411EC1000B49E1.
- Reset mid-fetch: accept A=2, assert reset at E1 for 1 cycle → no valid pulse; outputs are 0; fetch_ready_o=1 on the cycle after reset drops; a new fetch of A=0 is correct.
- Load during fetch: accept A=0; at E1 write byte 5=FF → data=0x11C1125F21FF1EC1, because word 1 is read at E2. A write to byte 1 at E1 is not visible, because word 0 is read at E1 and returns old data.
